// File: rtl/gpu_cmd_feeder.sv
// gpu_cmd_feeder: buffers CPU command/parameter pairs and serialises them onto
// the GPU's handshake-free cpuline slot protocol (cmd, param, exec | NOP, x).
// Optional build macro GPU_FEED_FILTER_EN drops pushes of unsupported opcodes
// (anything outside 0x00C0..0x00C6) and flags them on the sticky bad_cmd.
module gpu_cmd_feeder #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [15:0]       wr_cmd,
  input  logic [15:0]       wr_param,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              busy,
  output logic              overflow,
  output logic              bad_cmd,
  output logic [15:0]       cpuline
);

  // Each state names the word the GPU samples at the coming edge.
  typedef enum logic [1:0] {
    S_CMD   = 2'd0,
    S_PARAM = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              real_q, real_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              bad_cmd_q, bad_cmd_d;
  logic [31:0]       mem_q [DEPTH];

  logic [31:0]       head;
  logic              pop;
  logic              push_ok;
  logic              cmd_legal;

  assign head  = mem_q[rd_ptr_q];
  assign full  = (level_q == (ADDR_W+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  // Idle NOP slots do not count as work in progress.
  assign busy  = !empty || (state_q == S_EXEC) || ((state_q == S_PARAM) && real_q);
  assign overflow = overflow_q;
  assign bad_cmd  = bad_cmd_q;

  // Opcode filter: legal range only when the filter is built in.
  always_comb begin
`ifdef GPU_FEED_FILTER_EN
    cmd_legal = (wr_cmd >= 16'h00C0) && (wr_cmd <= 16'h00C6);
`else
    cmd_legal = 1'b1;
`endif
  end

  // Phase FSM: next state, real flag, pop strobe and cpuline decode.
  always_comb begin
    state_d = state_q;
    real_d  = real_q;
    pop     = 1'b0;
    cpuline = '0;
    case (state_q)
      S_CMD: begin
        if (!empty) begin
          cpuline = head[31:16];
          real_d  = 1'b1;
        end else begin
          real_d  = 1'b0;
        end
        state_d = S_PARAM;
      end
      S_PARAM: begin
        if (real_q) begin
          cpuline = head[15:0];
          pop     = 1'b1;
          state_d = S_EXEC;
        end else begin
          state_d = S_CMD;
        end
      end
      S_EXEC:  state_d = S_CMD;
      default: state_d = S_CMD;
    endcase
  end

  // FIFO bookkeeping: push acceptance, pointers, level and sticky flags.
  always_comb begin
    push_ok    = wr_en && cmd_legal && (!full || pop);
    overflow_d = overflow_q || (wr_en && cmd_legal && full && !pop);
    bad_cmd_d  = bad_cmd_q || (wr_en && !cmd_legal);
    wr_ptr_d   = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CMD;
      real_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      bad_cmd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      real_q     <= real_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      bad_cmd_q  <= bad_cmd_d;
    end
  end

  // Entry storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem_q[wr_ptr_q] <= {wr_cmd, wr_param};
    end
  end

endmodule

// File: tb/tb_gpu_cmd_feeder.sv
// tb_gpu_cmd_feeder: random pushes and occasional resets against a slot-level
// reference model (entry queue plus list of words left in the current slot).
module tb_gpu_cmd_feeder;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NCYC   = 3000;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [15:0]       wr_cmd;
  logic [15:0]       wr_param;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              busy;
  logic              overflow;
  logic              bad_cmd;
  logic [15:0]       cpuline;

  gpu_cmd_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_param(wr_param),
    .full(full), .empty(empty), .level(level), .busy(busy),
    .overflow(overflow), .bad_cmd(bad_cmd), .cpuline(cpuline)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: queued {cmd,param} entries; words still to come in the
  // current slot (1 = parameter word that retires the head, 0 = zero word).
  logic [31:0] mq[$];
  int          pend[$];
  bit          slot_real;
  bit          m_ovf, m_bad;

  function automatic bit legal(input logic [15:0] c);
`ifdef GPU_FEED_FILTER_EN
    return (c >= 16'h00C0) && (c <= 16'h00C6);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge(input bit rst, input bit we, input logic [15:0] c, input logic [15:0] p);
    bit popped;
    bit was_full;
    int w;
    popped = 1'b0;
    if (rst) begin
      mq.delete(); pend.delete(); slot_real = 1'b0; m_ovf = 1'b0; m_bad = 1'b0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (pend.size() == 0) begin
      if (mq.size() > 0) begin pend.push_back(1); pend.push_back(0); slot_real = 1'b1; end
      else begin pend.push_back(0); slot_real = 1'b0; end
    end else begin
      w = pend.pop_front();
      if (w == 1) popped = 1'b1;
    end
    if (popped) void'(mq.pop_front());
    if (we) begin
      if (!legal(c)) m_bad = 1'b1;
      else if (was_full && !popped) m_ovf = 1'b1;
      else mq.push_back({c, p});
    end
  endtask

  task automatic check_outputs();
    logic [15:0] exp_line;
    logic [31:0] hd;
    bit          exp_busy;
    if (pend.size() == 0) begin
      if (mq.size() > 0) begin hd = mq[0]; exp_line = hd[31:16]; end
      else exp_line = 16'h0000;
    end else if (pend[0] == 1) begin
      hd = mq[0]; exp_line = hd[15:0];
    end else exp_line = 16'h0000;
    exp_busy = (mq.size() > 0) || (pend.size() > 0 && slot_real);
    check("cpuline",  32'(cpuline),  32'(exp_line));
    check("level",    32'(level),    32'(mq.size()));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("full",     32'(full),     32'(mq.size() == DEPTH));
    check("busy",     32'(busy),     32'(exp_busy));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("bad_cmd",  32'(bad_cmd),  32'(m_bad));
  endtask

  initial begin
    int pct;
    reset = 1'b1; wr_en = 1'b0; wr_cmd = '0; wr_param = '0;
    slot_real = 1'b0; m_ovf = 1'b0; m_bad = 1'b0;
    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      model_edge(reset, wr_en, wr_cmd, wr_param);
      check_outputs();
      // Next-cycle stimulus: alternating push density so the FIFO both idles
      // and saturates; sparse resets land in arbitrary slot phases.
      case ((cyc / 150) % 4)
        0: pct = 5;
        1: pct = 95;
        2: pct = 40;
        default: pct = 100;
      endcase
      reset = (cyc < 2) || ($urandom_range(0, 249) == 0);
      wr_en = ($urandom_range(0, 99) < pct);
      case ($urandom_range(0, 15))
        0:       wr_cmd = 16'h0000;
        1:       wr_cmd = 16'h00C7;
        2:       wr_cmd = 16'($urandom);
        default: wr_cmd = 16'h00C0 + 16'($urandom_range(0, 6));
      endcase
      wr_param = 16'($urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
